// File: rtl/ysyx_041514_icache_pkg.sv
// rtl/ysyx_041514_icache_pkg.sv - shared types and sizes for the instruction cache
package ysyx_041514_icache_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REQ    = 2'd1,
        ST_REFILL = 2'd2
    } state_e;

    localparam int LINE_W       = 128;
    localparam int BEAT_W       = 64;
    localparam int BEATS        = LINE_W / BEAT_W;
    localparam int DEF_INDEX_W  = 4;
    localparam int DEF_OFFSET_W = 4;

endpackage

// File: rtl/ysyx_041514_icache_array.sv
// rtl/ysyx_041514_icache_array.sv - tag/valid/data storage, combinational read, synchronous write
module ysyx_041514_icache_array
    import ysyx_041514_icache_pkg::*;
#(
    parameter int INDEX_W = DEF_INDEX_W,
    parameter int TAG_W   = 24
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [INDEX_W-1:0] rd_index_i,
    output logic               rd_valid_o,
    output logic [TAG_W-1:0]   rd_tag_o,
    output logic [LINE_W-1:0]  rd_data_o,
    input  logic               wr_en_i,
    input  logic               wr_valid_i,
    input  logic [INDEX_W-1:0] wr_index_i,
    input  logic [TAG_W-1:0]   wr_tag_i,
    input  logic [LINE_W-1:0]  wr_data_i,
    input  logic               clear_all_i
);

    localparam int NLINES = 1 << INDEX_W;

    logic [NLINES-1:0] valid_q;
    logic [NLINES-1:0] valid_d;
    logic [TAG_W-1:0]  tag_q  [NLINES];
    logic [LINE_W-1:0] data_q [NLINES];

    // A write landing together with a clear-all still decides its own line's valid bit.
    always_comb begin
        valid_d = clear_all_i ? '0 : valid_q;
        if (wr_en_i) begin
            valid_d[wr_index_i] = wr_valid_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            tag_q[wr_index_i]  <= wr_tag_i;
            data_q[wr_index_i] <= wr_data_i;
        end
    end

    assign rd_valid_o = valid_q[rd_index_i];
    assign rd_tag_o   = tag_q[rd_index_i];
    assign rd_data_o  = data_q[rd_index_i];

endmodule

// File: rtl/ysyx_041514_icache_lite.sv
// rtl/ysyx_041514_icache_lite.sv - direct-mapped blocking icache: lookup, refill FSM, output mux
module ysyx_041514_icache_lite
    import ysyx_041514_icache_pkg::*;
#(
    parameter int INDEX_W  = DEF_INDEX_W,
    parameter int OFFSET_W = DEF_OFFSET_W,
    parameter int PADDR_W  = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               if_req_valid_i,
    input  logic [63:0]        inst_addr_i,
    input  logic               flush_i,
    output logic               if_rdata_valid_o,
    output logic [63:0]        if_rdata_o,
    output logic               mem_req_valid_o,
    input  logic               mem_req_ready_i,
    output logic [PADDR_W-1:0] mem_req_addr_o,
    input  logic               mem_rsp_valid_i,
    input  logic [63:0]        mem_rsp_data_i,
    input  logic               mem_rsp_last_i
);

    localparam int TAG_W = PADDR_W - OFFSET_W - INDEX_W;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    state_e             state_q;
    logic [PADDR_W-1:0] miss_addr_q;
    logic               mem_req_valid_q;
    logic [CNT_W-1:0]   beat_cnt_q;
    logic [LINE_W-1:0]  line_buf_q;
    logic [LINE_W-1:0]  line_buf_d;
    logic               flush_pend_q;

    logic [TAG_W-1:0]   req_tag;
    logic [INDEX_W-1:0] req_index;
    logic [1:0]         word_sel;
    logic               arr_valid;
    logic [TAG_W-1:0]   arr_tag;
    logic [LINE_W-1:0]  arr_data;
    logic [31:0]        hit_word;
    logic               hit;
    logic               miss;
    logic               refill_done;
    logic               unused_bits;

    assign req_tag   = inst_addr_i[PADDR_W-1:OFFSET_W+INDEX_W];
    assign req_index = inst_addr_i[OFFSET_W+INDEX_W-1:OFFSET_W];
    assign word_sel  = inst_addr_i[3:2];
    assign unused_bits = ^{inst_addr_i[63:PADDR_W], inst_addr_i[1:0], miss_addr_q[OFFSET_W-1:0]};

    assign hit  = if_req_valid_i && (state_q == ST_IDLE) && arr_valid &&
                  (arr_tag == req_tag) && !flush_i;
    assign miss = if_req_valid_i && (state_q == ST_IDLE) && !hit;
    assign refill_done = (state_q == ST_REFILL) && mem_rsp_valid_i && mem_rsp_last_i;

    assign hit_word         = arr_data[word_sel*32 +: 32];
    assign if_rdata_valid_o = hit;
    assign if_rdata_o       = hit ? {32'b0, hit_word} : 64'b0;
    assign mem_req_valid_o  = mem_req_valid_q;
    assign mem_req_addr_o   = miss_addr_q;

    // The final beat bypasses the buffer so the array write sees the complete line.
    always_comb begin
        line_buf_d = line_buf_q;
        line_buf_d[beat_cnt_q*BEAT_W +: BEAT_W] = mem_rsp_data_i;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            miss_addr_q     <= '0;
            mem_req_valid_q <= 1'b0;
            beat_cnt_q      <= '0;
            line_buf_q      <= '0;
            flush_pend_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (miss) begin
                        miss_addr_q     <= {inst_addr_i[PADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
                        mem_req_valid_q <= 1'b1;
                        state_q         <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (mem_req_ready_i) begin
                        mem_req_valid_q <= 1'b0;
                        beat_cnt_q      <= '0;
                        state_q         <= ST_REFILL;
                    end
                end
                ST_REFILL: begin
                    if (flush_i) begin
                        flush_pend_q <= 1'b1;
                    end
                    if (mem_rsp_valid_i) begin
                        line_buf_q <= line_buf_d;
                        beat_cnt_q <= beat_cnt_q + 1'b1;
                        if (mem_rsp_last_i) begin
                            flush_pend_q <= 1'b0;
                            state_q      <= ST_IDLE;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    ysyx_041514_icache_array #(
        .INDEX_W (INDEX_W),
        .TAG_W   (TAG_W)
    ) u_array (
        .clk         (clk),
        .rst         (rst),
        .rd_index_i  (req_index),
        .rd_valid_o  (arr_valid),
        .rd_tag_o    (arr_tag),
        .rd_data_o   (arr_data),
        .wr_en_i     (refill_done),
        .wr_valid_i  (!flush_pend_q && !flush_i),
        .wr_index_i  (miss_addr_q[OFFSET_W+INDEX_W-1:OFFSET_W]),
        .wr_tag_i    (miss_addr_q[PADDR_W-1:OFFSET_W+INDEX_W]),
        .wr_data_i   (line_buf_d),
        .clear_all_i (flush_i)
    );

endmodule

// File: tb/tb_ysyx_041514_icache_lite.sv
// tb/tb_ysyx_041514_icache_lite.sv - randomized scoreboard bench for the instruction cache
module tb_ysyx_041514_icache_lite;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req_valid_i;
    logic [63:0] inst_addr_i;
    logic        flush_i;
    logic        if_rdata_valid_o;
    logic [63:0] if_rdata_o;
    logic        mem_req_valid_o;
    logic        mem_req_ready_i;
    logic [31:0] mem_req_addr_o;
    logic        mem_rsp_valid_i;
    logic [63:0] mem_rsp_data_i;
    logic        mem_rsp_last_i;

    ysyx_041514_icache_lite dut (
        .clk              (clk),
        .rst              (rst),
        .if_req_valid_i   (if_req_valid_i),
        .inst_addr_i      (inst_addr_i),
        .flush_i          (flush_i),
        .if_rdata_valid_o (if_rdata_valid_o),
        .if_rdata_o       (if_rdata_o),
        .mem_req_valid_o  (mem_req_valid_o),
        .mem_req_ready_i  (mem_req_ready_i),
        .mem_req_addr_o   (mem_req_addr_o),
        .mem_rsp_valid_i  (mem_rsp_valid_i),
        .mem_rsp_data_i   (mem_rsp_data_i),
        .mem_rsp_last_i   (mem_rsp_last_i)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [63:0] exp_q[$];
    logic        started = 1'b0;

    // Reference cache state: which line each index currently holds.
    logic        mvalid [16];
    logic [23:0] mtag   [16];

    // Shared between the fetch driver and the memory responder.
    logic [31:0] exp_line;
    int          refills;
    int          disrupts;
    int          r_delay;
    bit          r_flush;
    bit          r_rst;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] mem64(input logic [31:0] a);
        if (a == 32'h8000_0000) return 64'h1111_2222_3333_4444;
        if (a == 32'h8000_0008) return 64'h5555_6666_7777_8888;
        return {~a, a ^ 32'h9e37_79b9};
    endfunction

    function automatic logic [31:0] exp_word(input logic [31:0] a);
        logic [63:0] b;
        b = mem64({a[31:3], 3'b000});
        return a[2] ? b[63:32] : b[31:0];
    endfunction

    task automatic fetch(input logic [63:0] addr);
        logic [31:0] pa;
        int          idx;
        logic [23:0] tg;
        bit          mhit;
        bit          got;
        int          waited;
        pa     = addr[31:0];
        idx    = int'(pa[7:4]);
        tg     = pa[31:8];
        mhit   = mvalid[idx] && (mtag[idx] == tg);
        waited = 0;
        exp_q.push_back({32'b0, exp_word(pa)});
        exp_line = {pa[31:4], 4'b0000};
        refills  = 0;
        disrupts = 0;
        if_req_valid_i = 1'b1;
        inst_addr_i    = addr;
        @(negedge clk);
        check("first_cycle_hit", {63'b0, if_rdata_valid_o}, {63'b0, mhit});
        got = if_rdata_valid_o;
        while (!got && waited < 200) begin
            @(negedge clk);
            waited++;
            got = if_rdata_valid_o;
        end
        if (!got) begin
            n_cmp++;
            n_err++;
            $display("FAIL hit_timeout: no hit for 0x%0h within 200 cycles", addr);
            exp_q.delete();
        end
        check("refill_count", 64'(refills), mhit ? 64'd0 : 64'(1 + disrupts));
        if (disrupts > 0) begin
            for (int i = 0; i < 16; i++) mvalid[i] = 1'b0;
        end
        mvalid[idx] = 1'b1;
        mtag[idx]   = tg;
        @(posedge clk);
        #1;
        if_req_valid_i = 1'b0;
    endtask

    task automatic idle_flush();
        flush_i = 1'b1;
        @(posedge clk);
        #1;
        flush_i = 1'b0;
        for (int i = 0; i < 16; i++) mvalid[i] = 1'b0;
    endtask

    // Monitor: every presented instruction is matched against the scoreboard.
    always @(negedge clk) begin
        if (started && !rst) begin
            if (if_rdata_valid_o) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_hit: rdata 0x%0h with empty scoreboard", if_rdata_o);
                end else begin
                    check("rdata", if_rdata_o, exp_q.pop_front());
                end
            end else begin
                check("rdata_zero_when_invalid", if_rdata_o, 64'd0);
            end
        end
    end

    // Memory responder: accepts refill requests and returns two beats.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (started && !rst && mem_req_valid_o) begin
                check("req_addr", {32'b0, mem_req_addr_o}, {32'b0, exp_line});
                repeat (r_delay) begin
                    @(posedge clk);
                    #1;
                    check("req_held_valid", {63'b0, mem_req_valid_o}, 64'd1);
                    check("req_held_addr", {32'b0, mem_req_addr_o}, {32'b0, exp_line});
                end
                mem_req_ready_i = 1'b1;
                @(posedge clk);
                #1;
                mem_req_ready_i = 1'b0;
                refills++;
                for (int i = 0; i < 2; i++) begin
                    repeat ($urandom_range(0, 2)) begin
                        mem_rsp_data_i = {$urandom, $urandom};
                        @(posedge clk);
                        #1;
                    end
                    if (i == 1 && r_flush) begin
                        flush_i = 1'b1;
                        @(posedge clk);
                        #1;
                        flush_i = 1'b0;
                        disrupts++;
                    end
                    if (i == 1 && r_rst) begin
                        rst = 1'b1;
                        @(posedge clk);
                        #1;
                        rst = 1'b0;
                        disrupts++;
                        check("rst_req_valid", {63'b0, mem_req_valid_o}, 64'd0);
                        check("rst_req_addr", {32'b0, mem_req_addr_o}, 64'd0);
                    end
                    mem_rsp_valid_i = 1'b1;
                    mem_rsp_data_i  = mem64(exp_line + 32'(i * 8));
                    mem_rsp_last_i  = (i == 1);
                    @(posedge clk);
                    #1;
                    mem_rsp_valid_i = 1'b0;
                    mem_rsp_last_i  = 1'b0;
                end
                r_flush = 1'b0;
                r_rst   = 1'b0;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
        $fatal(1);
    end

    initial begin
        logic [31:0] pa;
        for (int i = 0; i < 16; i++) begin
            mvalid[i] = 1'b0;
            mtag[i]   = '0;
        end
        rst             = 1'b1;
        if_req_valid_i  = 1'b1;
        inst_addr_i     = 64'h8000_0000;
        flush_i         = 1'b0;
        mem_req_ready_i = 1'b0;
        mem_rsp_valid_i = 1'b0;
        mem_rsp_data_i  = '0;
        mem_rsp_last_i  = 1'b0;
        exp_line        = '0;
        refills         = 0;
        disrupts        = 0;
        r_delay         = 0;
        r_flush         = 1'b0;
        r_rst           = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_rdata_valid", {63'b0, if_rdata_valid_o}, 64'd0);
        check("reset_rdata", if_rdata_o, 64'd0);
        check("reset_req_valid", {63'b0, mem_req_valid_o}, 64'd0);
        check("reset_req_addr", {32'b0, mem_req_addr_o}, 64'd0);
        if_req_valid_i = 1'b0;
        rst     = 1'b0;
        started = 1'b1;
        @(posedge clk);
        #1;

        fetch(64'h8000_0000);
        fetch(64'h8000_000C);
        fetch(64'h8000_0100);
        fetch(64'h8000_0000);
        r_delay = 5;
        fetch(64'h8000_0200);
        r_delay = 0;
        r_flush = 1'b1;
        fetch(64'h8000_0000);
        fetch(64'h8000_0004);
        r_rst = 1'b1;
        fetch(64'h8000_0040);
        fetch(64'h8000_0048);
        idle_flush();
        fetch(64'h8000_0048);

        for (int n = 0; n < 300; n++) begin
            pa = 32'h8000_0000 + 32'($urandom_range(0, 23) * 16) + 32'($urandom_range(0, 3) * 4);
            r_delay = $urandom_range(0, 3);
            r_flush = ($urandom_range(0, 15) == 0);
            r_rst   = !r_flush && ($urandom_range(0, 31) == 0);
            if ($urandom_range(0, 19) == 0) idle_flush();
            fetch({$urandom, pa});
        end

        repeat (5) @(posedge clk);
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ysyx_041514_icache_lite.md
# ysyx_041514_icache_lite

Direct-mapped, blocking instruction cache that serves the fetch stage. It sits between `pc_reg`/fetch and the memory bus. A lookup is combinational against registered tag, valid and data arrays, so `if_rdata_valid_o`/`if_rdata_o` can be returned in the same cycle as `inst_addr_i`. On a miss it holds `if_rdata_valid_o` low, which stalls the pipeline through the fetch stall request, and refills one line over a request/burst-response memory handshake.

## Interface
Parameters:
- `INDEX_W`, 4: line index bits (16 lines).
- `OFFSET_W`, 4: byte offset bits (16-byte line = 2 beats of 64 bits).
- `PADDR_W`, 32: physical address bits used for tag/index; upper `inst_addr_i` bits ignored.

Ports:
- `clk` in 1: clock.
- `rst` in 1: asynchronous, active-high reset.
- `if_req_valid_i` in 1: fetch requests the word at `inst_addr_i`.
- `inst_addr_i` in 64: instruction address, 4-byte aligned.
- `flush_i` in 1: one-cycle pulse from fence.i that invalidates all lines.
- `if_rdata_valid_o` out 1: `if_rdata_o` holds the instruction for `inst_addr_i` this cycle.
- `if_rdata_o` out 64: instruction in [31:0], zeros in [63:32].
- `mem_req_valid_o` out 1: line refill request.
- `mem_req_ready_i` in 1: memory accepts the request.
- `mem_req_addr_o` out 32: line-aligned refill address.
- `mem_rsp_valid_i` in 1: response beat valid.
- `mem_rsp_data_i` in 64: beat data, lower address first.
- `mem_rsp_last_i` in 1: final beat.

## Operation
- Address split:
  - tag = `inst_addr_i[PADDR_W-1:OFFSET_W+INDEX_W]`
  - index = `[OFFSET_W+INDEX_W-1:OFFSET_W]`
  - word select = `[3:2]`, where beat = bit 3 and half = bit 2.
- Hit condition: `if_req_valid_i & state==IDLE & valid[index] & tag match & !flush_i`. `if_rdata_valid_o` is driven as that combinational hit.
- FSM:
  - IDLE: on a miss, latch the line address into `miss_addr` and go to REQ.
  - REQ: `mem_req_valid_o=1`, with `mem_req_addr_o=miss_addr` held stable. On `mem_req_ready_i`, go to REFILL and clear the beat counter.
  - REFILL: each `mem_rsp_valid_i` beat writes into the line buffer at the beat counter, then the counter increments. On the beat with `mem_rsp_last_i`:
    - write tag, data and valid for `miss_addr`;
    - go to IDLE.
  - The next cycle hits, provided `inst_addr_i` is unchanged.
- Beats beyond 2 without `last` wrap the 1-bit counter and overwrite. Beats received in IDLE or REQ are ignored.
- `inst_addr_i` changes during REQ/REFILL: the refill of the latched line completes, and the new address is looked up in IDLE.
- `flush_i` in IDLE or REQ: clears all valid bits at the next edge; an outstanding REQ proceeds.
- `flush_i` in REFILL: clears all valid bits and sets `flush_pend`. The completing refill then writes data but not its valid bit; `flush_pend` clears on return to IDLE.
- Replacement is direct-mapped: the line at the index is overwritten unconditionally.
- Reset mid-operation: state returns to IDLE, all valid bits and `flush_pend` clear, and any in-flight memory response is ignored.

## Timing
- Reset values:
  - `if_rdata_valid_o=0`, `if_rdata_o=0`
  - `mem_req_valid_o=0`, `mem_req_addr_o=0`
  - all valid bits 0, state IDLE.
- Hit latency: 0 cycles (same cycle as the address).
- Miss penalty, with ready in the first REQ cycle and beats on consecutive cycles:
  - miss detected at cycle 0;
  - REQ at cycle 1;
  - beats at cycles 2–3 at the earliest;
  - hit at cycle 4.
- `if_rdata_o` is 0 whenever `if_rdata_valid_o=0`.
- `mem_req_valid_o` never drops before `mem_req_ready_i`.

## Structure
- The shared package `ysyx_041514_icache_pkg` holds:
  - state encoding (IDLE/REQ/REFILL);
  - `LINE_W=128`;
  - default `INDEX_W`/`OFFSET_W`;
  - the beat count.
- Sub-module `ysyx_041514_icache_array` holds the tag, valid and data registers:
  - combinational read port;
  - synchronous write port;
  - asynchronous valid clear on reset;
  - synchronous clear-all for flush.
- The top level holds the FSM, beat counter, line buffer and output muxing.

## Test plan
- Reset, then request `0x8000_0000`: `if_rdata_valid_o=0` and `mem_req_addr_o=0x8000_0000`. Return beats `0x1111_2222_3333_4444` and `0x5555_6666_7777_8888` (last) → the next cycle hits with `if_rdata_o=0x3333_4444`.
- Then request `0x8000_000C` → same-cycle hit, `if_rdata_o=0x5555_6666`.
- Request `0x8000_0100` (index 0, different tag) → miss and refill to `0x8000_0100`. `0x8000_0000` then misses again.
- Hold `mem_req_ready_i=0` for 5 cycles on a miss → `mem_req_valid_o` stays 1 and `mem_req_addr_o` stays stable for all 5 cycles.
- Pulse `flush_i` between the two refill beats → the refill completes, then `0x8000_0000` misses (new REQ issued).
- Assert `rst` mid-REFILL, then drive the remaining beat → state is IDLE, `mem_req_valid_o=0`, the beat is ignored, and a subsequent request misses.
